// File: rtl/uart_mitm_relay_pkg.sv
// Shared definitions for the UART MITM relay: TX FSM encodings and timing constants.
package uart_mitm_relay_pkg;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_START     = 2'd1,
    ST_WAIT_BUSY = 2'd2,
    ST_WAIT_DONE = 2'd3
  } relay_state_e;

  // Cycles spent in WAIT_BUSY before a start that the driver never took is abandoned
  localparam int unsigned BUSY_TIMEOUT = 4;
  localparam int unsigned BUSY_CNT_W   = 3;

endpackage

// File: rtl/uart_mitm_relay_sync_fifo.sv
// Synchronous FIFO with a first-word-fall-through head and an explicit occupancy count.
module sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 16
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         push,
  input  logic                         pop,
  input  logic [WIDTH-1:0]             din,
  output logic [WIDTH-1:0]             dout,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         full,
  output logic                         empty
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = $clog2(DEPTH+1);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;
  logic             w_do_push;
  logic             w_do_pop;

  assign full      = (r_count == CNT_W'(DEPTH));
  assign empty     = (r_count == '0);
  // A full queue still accepts a push when the head leaves in the same cycle
  assign w_do_push = push & (~full | pop);
  assign w_do_pop  = pop & ~empty;
  assign dout      = r_mem[r_rd_ptr];
  assign count     = r_count;

  always_ff @(posedge clk) begin
    if (w_do_push) begin
      r_mem[r_wr_ptr] <= din;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) begin
        r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      end
      if (w_do_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      end
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/uart_mitm_relay.sv
// UART man-in-the-middle relay: captures RX frames, optionally substitutes one value,
// queues them and replays to the TX driver, with injected frames taking priority.
module uart_mitm_relay
  import uart_mitm_relay_pkg::*;
#(
  parameter int unsigned NUM_DATA_BITS = 8,
  parameter int unsigned FIFO_DEPTH    = 16,
  parameter int unsigned CNT_WIDTH     = 16
) (
  input  logic                              sys_clk,
  input  logic                              rst_n,
  input  logic                              rx_new_data,
  input  logic [NUM_DATA_BITS-1:0]          rx_data,
  input  logic                              tx_ready,
  output logic                              cmd_tx_start,
  output logic [NUM_DATA_BITS-1:0]          tx_data,
  input  logic                              pass_en,
  input  logic                              cfg_match_en,
  input  logic [NUM_DATA_BITS-1:0]          cfg_match_data,
  input  logic [NUM_DATA_BITS-1:0]          cfg_replace_data,
  input  logic                              inj_valid,
  input  logic [NUM_DATA_BITS-1:0]          inj_data,
  output logic                              inj_ready,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]   fifo_count,
  output logic                              overflow,
  output logic [CNT_WIDTH-1:0]              drop_cnt
);

  localparam int unsigned FCNT_W = $clog2(FIFO_DEPTH+1);

  relay_state_e               r_state;
  logic                       r_rx_q;
  logic [BUSY_CNT_W-1:0]      r_busy_cnt;
  logic                       r_overflow;
  logic [CNT_WIDTH-1:0]       r_drop_cnt;
  logic [NUM_DATA_BITS-1:0]   r_tx_data;
  logic                       r_cmd_tx_start;

  logic                       w_rx_edge;
  logic                       w_push;
  logic [NUM_DATA_BITS-1:0]   w_push_data;
  logic                       w_sel;
  logic                       w_pop;
  logic                       w_drop;
  logic [NUM_DATA_BITS-1:0]   w_fifo_dout;
  logic [FCNT_W-1:0]          w_fifo_count;
  logic                       w_fifo_full;
  logic                       w_fifo_empty;

  assign w_rx_edge   = rx_new_data & ~r_rx_q;
  assign w_push      = w_rx_edge & pass_en;
  assign w_push_data = (cfg_match_en && (rx_data == cfg_match_data)) ? cfg_replace_data : rx_data;

  // Selection needs a fresh tx_ready seen in IDLE; injection wins over the queue head
  assign w_sel  = (r_state == ST_IDLE) & tx_ready & (inj_valid | ~w_fifo_empty);
  assign w_pop  = w_sel & ~inj_valid;
  assign w_drop = w_push & w_fifo_full & ~w_pop;

  assign inj_ready    = w_sel & inj_valid;
  assign cmd_tx_start = r_cmd_tx_start;
  assign tx_data      = r_tx_data;
  assign fifo_count   = w_fifo_count;
  assign overflow     = r_overflow;
  assign drop_cnt     = r_drop_cnt;

  sync_fifo #(
    .WIDTH (NUM_DATA_BITS),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (sys_clk),
    .rst_n (rst_n),
    .push  (w_push),
    .pop   (w_pop),
    .din   (w_push_data),
    .dout  (w_fifo_dout),
    .count (w_fifo_count),
    .full  (w_fifo_full),
    .empty (w_fifo_empty)
  );

  // Edge register resets high so a level already asserted at release is ignored
  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rx_q     <= 1'b1;
      r_overflow <= 1'b0;
      r_drop_cnt <= '0;
    end else begin
      r_rx_q     <= rx_new_data;
      r_overflow <= w_drop;
      if (w_drop && (r_drop_cnt != '1)) begin
        r_drop_cnt <= r_drop_cnt + CNT_WIDTH'(1);
      end
    end
  end

  // TX handshake FSM with registered start pulse and frame data
  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state        <= ST_IDLE;
      r_busy_cnt     <= '0;
      r_tx_data      <= '0;
      r_cmd_tx_start <= 1'b0;
    end else begin
      r_cmd_tx_start <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_sel) begin
            r_tx_data      <= inj_valid ? inj_data : w_fifo_dout;
            r_cmd_tx_start <= 1'b1;
            r_state        <= ST_START;
          end
        end
        ST_START: begin
          r_busy_cnt <= '0;
          r_state    <= ST_WAIT_BUSY;
        end
        ST_WAIT_BUSY: begin
          if (!tx_ready) begin
            r_state <= ST_WAIT_DONE;
          end else if (r_busy_cnt == BUSY_CNT_W'(BUSY_TIMEOUT - 1)) begin
            r_state <= ST_IDLE;
          end else begin
            r_busy_cnt <= r_busy_cnt + BUSY_CNT_W'(1);
          end
        end
        ST_WAIT_DONE: begin
          if (tx_ready) begin
            r_state <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_mitm_relay.sv
// Scoreboard bench for uart_mitm_relay: a behavioural UART driver answers start pulses
// and a monitor checks every transmitted frame against the expected queue.
module tb_uart_mitm_relay;

  logic       sys_clk = 1'b0;
  logic       rst_n;
  logic       rx_new_data;
  logic [7:0] rx_data;
  logic       tx_ready;
  logic       cmd_tx_start;
  logic [7:0] tx_data;
  logic       pass_en;
  logic       cfg_match_en;
  logic [7:0] cfg_match_data;
  logic [7:0] cfg_replace_data;
  logic       inj_valid;
  logic [7:0] inj_data;
  logic       inj_ready;
  logic [4:0] fifo_count;
  logic       overflow;
  logic [15:0] drop_cnt;

  int   n_checks = 0;
  int   n_errs   = 0;
  int   cyc      = 0;
  int   ovf_seen = 0;
  bit   hold_busy = 1'b0;
  int   busy_len  = 3;
  int   busy_left = 0;
  logic [7:0] exp_q[$];
  int         exp_cyc_q[$];

  uart_mitm_relay #(
    .NUM_DATA_BITS (8),
    .FIFO_DEPTH    (16),
    .CNT_WIDTH     (16)
  ) dut (
    .sys_clk          (sys_clk),
    .rst_n            (rst_n),
    .rx_new_data      (rx_new_data),
    .rx_data          (rx_data),
    .tx_ready         (tx_ready),
    .cmd_tx_start     (cmd_tx_start),
    .tx_data          (tx_data),
    .pass_en          (pass_en),
    .cfg_match_en     (cfg_match_en),
    .cfg_match_data   (cfg_match_data),
    .cfg_replace_data (cfg_replace_data),
    .inj_valid        (inj_valid),
    .inj_data         (inj_data),
    .inj_ready        (inj_ready),
    .fifo_count       (fifo_count),
    .overflow         (overflow),
    .drop_cnt         (drop_cnt)
  );

  always #5 sys_clk = ~sys_clk;

  initial forever begin
    @(posedge sys_clk);
    cyc++;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errs++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Behavioural driver: drops tx_ready for busy_len cycles after each start pulse
  initial begin
    tx_ready = 1'b1;
    forever begin
      @(negedge sys_clk);
      if (cmd_tx_start) begin
        busy_left = busy_len;
      end
      if (hold_busy || busy_left > 0) begin
        tx_ready = 1'b0;
        if (busy_left > 0) busy_left--;
      end else begin
        tx_ready = 1'b1;
      end
    end
  end

  // Monitor: every start pulse must match the scoreboard head
  initial forever begin
    @(negedge sys_clk);
    if (overflow) ovf_seen++;
    if (rst_n && cmd_tx_start) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_errs++;
        $display("FAIL unexpected_start: got tx_data=%0h with nothing expected", tx_data);
      end else begin
        logic [7:0] e;
        int         ec;
        e  = exp_q.pop_front();
        ec = exp_cyc_q.pop_front();
        chk("tx_frame", 32'(tx_data), 32'(e));
        if (ec >= 0) chk("start_latency", 32'(cyc), 32'(ec));
      end
    end
  end

  // Edge cycle = push, next = IDLE select, third = START with the pulse visible
  task automatic send_frame(input logic [7:0] d, input bit exp_en, input logic [7:0] exp_d,
                            input bit lat);
    @(negedge sys_clk);
    if (exp_en) begin
      exp_q.push_back(exp_d);
      exp_cyc_q.push_back(lat ? cyc + 2 : -1);
    end
    rx_data     = d;
    rx_new_data = 1'b1;
    @(negedge sys_clk);
    rx_new_data = 1'b0;
    @(negedge sys_clk);
  endtask

  task automatic expect_frame(input logic [7:0] d);
    exp_q.push_back(d);
    exp_cyc_q.push_back(-1);
  endtask

  task automatic wait_drain(input string name);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 400) begin
      @(negedge sys_clk);
      n++;
    end
    if (exp_q.size() != 0) begin
      n_checks++;
      n_errs++;
      $display("FAIL %s_drain_timeout: got %0d frames left expected 0", name, exp_q.size());
      exp_q.delete();
      exp_cyc_q.delete();
    end
    repeat (8) @(negedge sys_clk);
  endtask

  initial begin
    bit got;
    rst_n = 1'b0;
    rx_new_data = 1'b1;  // already high across reset release
    rx_data = 8'h77;
    pass_en = 1'b1;
    cfg_match_en = 1'b0;
    cfg_match_data = 8'h00;
    cfg_replace_data = 8'h00;
    inj_valid = 1'b0;
    inj_data = 8'h00;
    #22;
    chk("rst_cmd_tx_start", 32'(cmd_tx_start), 0);
    chk("rst_tx_data", 32'(tx_data), 0);
    chk("rst_inj_ready", 32'(inj_ready), 0);
    chk("rst_fifo_count", 32'(fifo_count), 0);
    chk("rst_overflow", 32'(overflow), 0);
    chk("rst_drop_cnt", 32'(drop_cnt), 0);
    @(negedge sys_clk);
    rst_n = 1'b1;
    repeat (5) @(negedge sys_clk);
    chk("high_at_release_no_push", 32'(fifo_count), 0);
    rx_new_data = 1'b0;
    repeat (3) @(negedge sys_clk);

    // Plain relay with latency check
    send_frame(8'h41, 1'b1, 8'h41, 1'b1);
    wait_drain("t1a");
    send_frame(8'h42, 1'b1, 8'h42, 1'b1);
    wait_drain("t1b");

    // Substitution of a matching value only
    cfg_match_en = 1'b1;
    cfg_match_data = 8'h55;
    cfg_replace_data = 8'hAA;
    send_frame(8'h55, 1'b1, 8'hAA, 1'b0);
    send_frame(8'h56, 1'b1, 8'h56, 1'b0);
    wait_drain("t2");
    cfg_match_en = 1'b0;

    // Overflow: 17 frames into a 16-entry queue while the driver is busy
    hold_busy = 1'b1;
    repeat (3) @(negedge sys_clk);
    ovf_seen = 0;
    for (int i = 0; i < 17; i++) begin
      send_frame(8'(8'h10 + i), (i < 16), 8'(8'h10 + i), 1'b0);
    end
    repeat (2) @(negedge sys_clk);
    chk("full_fifo_count", 32'(fifo_count), 16);
    chk("overflow_pulses", 32'(ovf_seen), 1);
    chk("drop_cnt_one", 32'(drop_cnt), 1);
    hold_busy = 1'b0;
    wait_drain("t3");
    chk("drained_fifo_count", 32'(fifo_count), 0);

    // Injection takes priority over a queued frame
    hold_busy = 1'b1;
    repeat (3) @(negedge sys_clk);
    send_frame(8'h01, 1'b0, 8'h00, 1'b0);
    expect_frame(8'hF0);
    expect_frame(8'h01);
    inj_data = 8'hF0;
    inj_valid = 1'b1;
    hold_busy = 1'b0;
    got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge sys_clk);
      #1;
      if (inj_ready) got = 1'b1;
    end
    chk("inj_ready_pulse", 32'(got), 1);
    @(negedge sys_clk);
    inj_valid = 1'b0;
    wait_drain("t4");

    // Reset while the driver is mid-frame with three frames queued
    busy_len = 20;
    send_frame(8'h31, 1'b1, 8'h31, 1'b1);
    send_frame(8'h32, 1'b0, 8'h00, 1'b0);
    send_frame(8'h33, 1'b0, 8'h00, 1'b0);
    send_frame(8'h34, 1'b0, 8'h00, 1'b0);
    chk("pre_reset_fifo_count", 32'(fifo_count), 3);
    chk("pre_reset_tx_data", 32'(tx_data), 32'h31);
    @(negedge sys_clk);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_cmd_tx_start", 32'(cmd_tx_start), 0);
    chk("mid_rst_tx_data", 32'(tx_data), 0);
    chk("mid_rst_fifo_count", 32'(fifo_count), 0);
    chk("mid_rst_inj_ready", 32'(inj_ready), 0);
    chk("mid_rst_overflow", 32'(overflow), 0);
    chk("mid_rst_drop_cnt", 32'(drop_cnt), 0);
    @(negedge sys_clk);
    rst_n = 1'b1;
    busy_len = 3;
    repeat (40) @(negedge sys_clk);
    chk("post_reset_fifo_count", 32'(fifo_count), 0);
    send_frame(8'h35, 1'b1, 8'h35, 1'b1);
    wait_drain("t5");

    // Discard mode: nothing queued, nothing counted
    pass_en = 1'b0;
    for (int i = 0; i < 5; i++) begin
      send_frame(8'(8'h60 + i), 1'b0, 8'h00, 1'b0);
    end
    repeat (5) @(negedge sys_clk);
    chk("discard_fifo_count", 32'(fifo_count), 0);
    chk("discard_drop_cnt", 32'(drop_cnt), 0);
    pass_en = 1'b1;
    repeat (10) @(negedge sys_clk);

    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

endmodule
